// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller.
// Holds the stall FSM state encoding, the forwarding-select codes, the
// hard-wired zero register number, and a helper that turns the two
// forwarding hits into a select code.
package hazard_pkg;

    // RUN: normal hazard evaluation. HOLD: second cycle of a branch-on-load stall.
    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } hz_state_e;

    // EX operand select codes
    localparam logic [1:0] FWD_RF  = 2'b00;   // register file
    localparam logic [1:0] FWD_MEM = 2'b10;   // EX/MEM pipeline register
    localparam logic [1:0] FWD_WB  = 2'b01;   // MEM/WB pipeline register

    // Register number that reads as constant zero and never creates a dependency
    localparam int REG_ZERO = 0;

    // The younger producer (EX/MEM) wins over the older one (MEM/WB)
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_ctrl_reg_match.sv
// reg_match: register-number comparator with a zero-register guard.
// Ports:
//   i_a, i_b  in  REG_AW  register numbers to compare
//   o_match   out 1       equal and not the zero register
module reg_match
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] i_a,
    input  logic [REG_AW-1:0] i_b,
    output logic              o_match
);

    // Register 0 is hard-wired, so it never carries a real dependency
    assign o_match = (i_a == i_b) && (i_a != REG_AW'(REG_ZERO));

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall, flush and forwarding control for a 5-stage pipeline
// whose branches resolve in ID.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   id_rs, id_rt, id_uses_rt, id_branch  instruction in ID
//   ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread  instruction in EX
//   mem_rd, mem_regwrite, mem_memread   instruction in MEM
//   wb_rd, wb_regwrite                  instruction in WB
//   kill                              pipeline flush
//   cnt_clr                           clear the stall counter
//   pc_en, ifid_en                    front-end write enables (low while stalled)
//   idex_bubble                       insert a NOP into ID/EX
//   fwd_a, fwd_b                      EX operand forwarding selects
//   fwd_br_a, fwd_br_b                ID branch operands taken from EX/MEM
//   stall_cnt                         saturating count of stalled cycles
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rt,
    input  logic              id_branch,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic              mem_memread,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              kill,
    input  logic              cnt_clr,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              idex_bubble,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              fwd_br_a,
    output logic              fwd_br_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    hz_state_e        r_state;
    hz_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic w_exrd_idrs, w_exrd_idrt;
    logic w_memrd_idrs, w_memrd_idrt;
    logic w_memrd_exrs, w_memrd_exrt;
    logic w_wbrd_exrs, w_wbrd_exrt;
    logic w_ex_match, w_mem_match, w_rt_live;
    logic w_lu, w_ba, w_bm, w_bl, w_hazard;
    logic w_stall;

    // Comparators: producers in EX/MEM against the ID sources
    reg_match #(.REG_AW(REG_AW)) u_exrd_idrs  (.i_a(ex_rd),  .i_b(id_rs), .o_match(w_exrd_idrs));
    reg_match #(.REG_AW(REG_AW)) u_exrd_idrt  (.i_a(ex_rd),  .i_b(id_rt), .o_match(w_exrd_idrt));
    reg_match #(.REG_AW(REG_AW)) u_memrd_idrs (.i_a(mem_rd), .i_b(id_rs), .o_match(w_memrd_idrs));
    reg_match #(.REG_AW(REG_AW)) u_memrd_idrt (.i_a(mem_rd), .i_b(id_rt), .o_match(w_memrd_idrt));
    // Comparators: producers in MEM/WB against the EX sources
    reg_match #(.REG_AW(REG_AW)) u_memrd_exrs (.i_a(mem_rd), .i_b(ex_rs), .o_match(w_memrd_exrs));
    reg_match #(.REG_AW(REG_AW)) u_memrd_exrt (.i_a(mem_rd), .i_b(ex_rt), .o_match(w_memrd_exrt));
    reg_match #(.REG_AW(REG_AW)) u_wbrd_exrs  (.i_a(wb_rd),  .i_b(ex_rs), .o_match(w_wbrd_exrs));
    reg_match #(.REG_AW(REG_AW)) u_wbrd_exrt  (.i_a(wb_rd),  .i_b(ex_rt), .o_match(w_wbrd_exrt));

    // rt is a real source for R-type ops and for both branch comparator inputs
    assign w_rt_live   = id_uses_rt | id_branch;
    assign w_ex_match  = w_exrd_idrs  | (w_rt_live & w_exrd_idrt);
    assign w_mem_match = w_memrd_idrs | (w_rt_live & w_memrd_idrt);

    assign w_lu     = ex_memread & w_ex_match;
    assign w_ba     = id_branch & ex_regwrite & ~ex_memread & w_ex_match;
    assign w_bm     = id_branch & mem_memread & w_mem_match;
    // A branch on a load still in EX needs two cycles: one here, one in HOLD
    assign w_bl     = id_branch & ex_memread & w_ex_match;
    assign w_hazard = w_lu | w_ba | w_bm | w_bl;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and stall decision; HOLD stalls without looking at hazards
    always_comb begin
        w_state_nxt = ST_RUN;
        w_stall     = 1'b0;
        case (r_state)
            ST_RUN: begin
                w_stall = w_hazard & ~kill;
                if (w_bl && !kill) begin
                    w_state_nxt = ST_HOLD;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HOLD: begin
                w_stall     = ~kill;
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_stall     = 1'b0;
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Stalled-cycle counter: clear beats increment, and it sticks at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (cnt_clr) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign pc_en       = ~w_stall;
    assign ifid_en     = ~w_stall;
    assign idex_bubble = w_stall | kill;

    assign fwd_a = fwd_sel(mem_regwrite & w_memrd_exrs, wb_regwrite & w_wbrd_exrs);
    assign fwd_b = fwd_sel(mem_regwrite & w_memrd_exrt, wb_regwrite & w_wbrd_exrt);

    // Only an ALU result is available in EX/MEM; a load value is not yet read
    assign fwd_br_a = id_branch & mem_regwrite & ~mem_memread & w_memrd_idrs;
    assign fwd_br_b = id_branch & mem_regwrite & ~mem_memread & w_memrd_idrt;

    assign stall_cnt = r_stall_cnt;

endmodule
